pbch_dmrs_gen_tx: RTL and testbench

PBCH_DMRS_GEN_TX -- requirements
Module: pbch_dmrs_gen_tx

---
 rtl/pbch_dmrs_gen_tx.sv | 143 ++++++++++++++
 tb/tb_pbch_dmrs_gen_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pbch_dmrs_gen_tx.sv
// PBCH DM-RS generator: Gold-sequence QPSK symbols (144 per block) for one SSB,
// streamed over AXI-Stream with symbol index in tuser and tlast on the final symbol.
module pbch_dmrs_gen_tx #(
    parameter int OUT_DW = 32,
    parameter int AMP    = 23170
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [9:0]        N_id_i,
    input  logic [2:0]        ibar_SSB_i,
    input  logic              start_i,
    output logic [OUT_DW-1:0] m_axis_out_tdata,
    output logic              m_axis_out_tvalid,
    input  logic              m_axis_out_tready,
    output logic              m_axis_out_tlast,
    output logic [7:0]        m_axis_out_tuser,
    output logic              busy_o,
    output logic              error_o,
    output logic [1:0]        dbg_state_o
);

    localparam int            HW        = OUT_DW / 2;
    localparam logic [HW-1:0] AMP_POS   = HW'(AMP);
    localparam logic [HW-1:0] AMP_NEG   = HW'(-AMP);
    localparam logic [9:0]    MAX_NID   = 10'd1007;
    localparam logic [9:0]    WARM_LAST = 10'd799;
    localparam logic [7:0]    LAST_SYM  = 8'd143;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        GEN    = 2'd2
    } state_t;

    state_t      state;
    logic [30:0] x1;
    logic [30:0] x2;
    logic [30:0] x1_adv;
    logic [30:0] x2_adv;
    logic [30:0] c_init;
    logic [9:0]  warm_cnt;
    logic [7:0]  next_m;
    logic [3:0]  ib1;
    logic [8:0]  nq1;
    logic [12:0] prod;
    logic        load;
    logic        xfer;
    logic        c_even;
    logic        c_odd;

    // Each register holds x(n) in bit 0; one step shifts right and feeds x(n+31) into bit 30.
    function automatic logic [30:0] x1_step2(input logic [30:0] x);
        logic [30:0] t;
        t = {x[3] ^ x[0], x[30:1]};
        return {t[3] ^ t[0], t[30:1]};
    endfunction

    function automatic logic [30:0] x2_step2(input logic [30:0] x);
        logic [30:0] t;
        t = {x[3] ^ x[2] ^ x[1] ^ x[0], x[30:1]};
        return {t[3] ^ t[2] ^ t[1] ^ t[0], t[30:1]};
    endfunction

    always_comb begin
        ib1    = {1'b0, ibar_SSB_i} + 4'd1;
        nq1    = {1'b0, N_id_i[9:2]} + 9'd1;
        prod   = 13'(ib1) * 13'(nq1);
        c_init = {7'd0, prod, 11'd0} + {21'd0, ib1, 6'd0} + {29'd0, N_id_i[1:0]};
    end

    assign x1_adv      = x1_step2(x1);
    assign x2_adv      = x2_step2(x2);
    assign c_even      = x1[0] ^ x2[0];
    assign c_odd       = x1[1] ^ x2[1];
    assign dbg_state_o = state;

    // Handshake: a symbol moves on a rising edge where tvalid and tready are both high;
    // while tvalid is high and tready low, tdata/tuser/tlast hold. The LFSRs always sit
    // one symbol ahead of the output register so a new symbol can be loaded on a transfer.
    assign xfer = m_axis_out_tvalid && m_axis_out_tready;
    assign load = (state == GEN) && (!m_axis_out_tvalid || (m_axis_out_tready && !m_axis_out_tlast));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state             <= IDLE;
            x1                <= '0;
            x2                <= '0;
            warm_cnt          <= '0;
            next_m            <= '0;
            m_axis_out_tdata  <= '0;
            m_axis_out_tvalid <= 1'b0;
            m_axis_out_tlast  <= 1'b0;
            m_axis_out_tuser  <= '0;
            busy_o            <= 1'b0;
            error_o           <= 1'b0;
        end else begin
            error_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (N_id_i <= MAX_NID) begin
                            x1       <= 31'd1;
                            x2       <= c_init;
                            warm_cnt <= '0;
                            next_m   <= '0;
                            busy_o   <= 1'b1;
                            state    <= WARMUP;
                        end else begin
                            error_o <= 1'b1;
                        end
                    end
                end
                WARMUP: begin
                    x1       <= x1_adv;
                    x2       <= x2_adv;
                    warm_cnt <= warm_cnt + 10'd1;
                    if (warm_cnt == WARM_LAST) begin
                        state <= GEN;
                    end
                end
                GEN: begin
                    if (load) begin
                        x1                <= x1_adv;
                        x2                <= x2_adv;
                        m_axis_out_tdata  <= {(c_odd ? AMP_NEG : AMP_POS), (c_even ? AMP_NEG : AMP_POS)};
                        m_axis_out_tuser  <= next_m;
                        m_axis_out_tlast  <= (next_m == LAST_SYM);
                        m_axis_out_tvalid <= 1'b1;
                        next_m            <= next_m + 8'd1;
                    end else if (xfer) begin
                        // Only reachable on the final symbol's transfer.
                        m_axis_out_tvalid <= 1'b0;
                        m_axis_out_tlast  <= 1'b0;
                        busy_o            <= 1'b0;
                        state             <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pbch_dmrs_gen_tx.sv
// Bench for pbch_dmrs_gen_tx: Gold-sequence reference model, scoreboard queue,
// per-cycle compare on the output stream, latency/error/reset/back-to-back scenarios.
module tb_pbch_dmrs_gen_tx;

    localparam int OUT_DW = 32;
    localparam int AMP    = 23170;
    localparam int EW     = OUT_DW + 9;
    localparam int NC     = 1600;
    localparam int SEQ_N  = NC + 288;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [9:0]        n_id = '0;
    logic [2:0]        ibar = '0;
    logic              start = 1'b0;
    logic [OUT_DW-1:0] tdata;
    logic              tvalid;
    logic              tready = 1'b0;
    logic              tlast;
    logic [7:0]        tuser;
    logic              busy;
    logic              error;
    logic [1:0]        dbg_state;

    int checks = 0;
    int errors = 0;
    int pop_cnt = 0;
    bit rand_ready = 1'b0;
    logic [EW-1:0] exp_q[$];

    pbch_dmrs_gen_tx #(.OUT_DW(OUT_DW), .AMP(AMP)) dut (
        .clk_i             (clk),
        .reset_i           (rst),
        .N_id_i            (n_id),
        .ibar_SSB_i        (ibar),
        .start_i           (start),
        .m_axis_out_tdata  (tdata),
        .m_axis_out_tvalid (tvalid),
        .m_axis_out_tready (tready),
        .m_axis_out_tlast  (tlast),
        .m_axis_out_tuser  (tuser),
        .busy_o            (busy),
        .error_o           (error),
        .dbg_state_o       (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint c_init_of(input int nid, input int ib);
        return 64'(2048) * (ib + 1) * (nid / 4 + 1) + 64 * (ib + 1) + (nid % 4);
    endfunction

    // Reference: textbook length-31 Gold sequence, c(n) = x1(n+Nc) ^ x2(n+Nc).
    function automatic void build_expected(input int nid, input int ib);
        bit x1m[SEQ_N];
        bit x2m[SEQ_N];
        longint ci;
        bit c0;
        bit c1;
        logic [15:0] iv;
        logic [15:0] qv;
        logic [7:0] mv;
        ci = c_init_of(nid, ib);
        for (int n = 0; n < 31; n++) begin
            x1m[n] = (n == 0);
            x2m[n] = ci[n];
        end
        for (int n = 0; n + 31 < SEQ_N; n++) begin
            x1m[n + 31] = x1m[n + 3] ^ x1m[n];
            x2m[n + 31] = x2m[n + 3] ^ x2m[n + 2] ^ x2m[n + 1] ^ x2m[n];
        end
        for (int m = 0; m < 144; m++) begin
            c0 = x1m[NC + 2 * m] ^ x2m[NC + 2 * m];
            c1 = x1m[NC + 2 * m + 1] ^ x2m[NC + 2 * m + 1];
            iv = c0 ? 16'(-AMP) : 16'(AMP);
            qv = c1 ? 16'(-AMP) : 16'(AMP);
            mv = 8'(m);
            exp_q.push_back({(m == 143), mv, qv, iv});
        end
    endfunction

    // Compare process: tready is chosen here, then the presented word is checked.
    logic [EW-1:0] prev_word;
    bit prev_stall = 1'b0;
    always @(negedge clk) begin
        tready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (rst) begin
            prev_stall = 1'b0;
        end else if (tvalid) begin
            if (prev_stall) begin
                checks++;
                if ({tlast, tuser, tdata} !== prev_word) begin
                    errors++;
                    $display("FAIL stall_hold: got %h expected %h", {tlast, tuser, tdata}, prev_word);
                end
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got tuser %0d expected no output", tuser);
            end else begin
                if ({tlast, tuser, tdata} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL symbol: got last %0b m %0d data %h expected last %0b m %0d data %h",
                             tlast, tuser, tdata, exp_q[0][EW-1], exp_q[0][EW-2:OUT_DW], exp_q[0][OUT_DW-1:0]);
                end
                if (tready) begin
                    void'(exp_q.pop_front());
                    pop_cnt++;
                end
            end
            prev_stall = !tready;
            prev_word  = {tlast, tuser, tdata};
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Called at a negedge; returns at a negedge.
    task automatic start_block(input int nid, input int ib, input bit accept);
        int n;
        n_id  = 10'(nid);
        ibar  = 3'(ib);
        start = 1'b1;
        if (accept) build_expected(nid, ib);
        @(posedge clk); #1;
        start = 1'b0;
        n_id  = 10'($urandom_range(0, 1023));
        ibar  = 3'($urandom_range(0, 7));
        check(accept ? "busy_after_start" : "busy_after_reject", busy, accept);
        check(accept ? "no_error_on_start" : "error_pulse", error, !accept);
        if (accept) begin
            n = 0;
            while (!tvalid && n < 1000) begin
                @(posedge clk); #1;
                n++;
            end
            check("first_valid_edge", n, 801);
        end else begin
            @(posedge clk); #1;
            check("error_one_cycle", error, 0);
            check("busy_stays_low", busy, 0);
        end
        @(negedge clk);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && !tvalid) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got %0d symbols pending expected 0", exp_q.size());
        end else begin
            check("busy_low_after_last", busy, 0);
            check("tlast_low_after_last", tlast, 0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tdata"}, tdata, 0);
        check({tag, "_tvalid"}, tvalid, 0);
        check({tag, "_tlast"}, tlast, 0);
        check({tag, "_tuser"}, tuser, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_state"}, dbg_state, 0);
    endtask

    initial begin
        int n;
        int base;
        #23;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("c_init_0_0", c_init_of(0, 0), 2112);
        check("c_init_1007_7", c_init_of(1007, 7), 4129283);
        check("c_init_1007_0", c_init_of(1007, 0), 516163);

        rand_ready = 1'b0;
        start_block(0, 0, 1);
        wait_done();
        start_block(1007, 7, 1);
        wait_done();

        rand_ready = 1'b1;
        start_block(0, 0, 1);
        wait_done();

        start_block(1008, 0, 0);
        repeat (20) @(negedge clk);
        start_block(1023, 5, 0);

        // Spurious start while running: ignored, no error, stream unchanged.
        start_block(5, 3, 1);
        start = 1'b1;
        n_id  = 10'd20;
        ibar  = 3'd1;
        @(posedge clk); #1;
        start = 1'b0;
        check("ignored_start_no_error", error, 0);
        check("ignored_start_busy", busy, 1);
        @(negedge clk);
        wait_done();

        // Reset partway through the stream.
        base = pop_cnt;
        start_block(300, 2, 1);
        n = 0;
        while (pop_cnt < base + 50 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("reached_symbol_50", pop_cnt >= base + 50, 1);
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        check_all_zero("midreset");
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("idle_after_reset", busy, 0);
        start_block(300, 2, 1);
        wait_done();

        // Back-to-back: new start in the cycle after the final transfer.
        rand_ready = 1'b0;
        start_block(17, 1, 1);
        n = 0;
        while (!(tvalid && tlast) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("saw_tlast", tvalid && tlast, 1);
        @(negedge clk);
        start_block(500, 6, 1);
        wait_done();

        rand_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            start_block($urandom_range(0, 1007), $urandom_range(0, 7), 1);
            wait_done();
        end

        check("queue_empty_at_end", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
